// File: rtl/alu_pkg.sv
// Shared definitions for the ALU loop sequencer: ALU opcode encodings and
// the sequencer state type.
package alu_pkg;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_INC = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ADD,
        INC,
        DONE
    } seq_state_t;

endpackage

// File: rtl/alu_loop_seq.sv
// Sequencer that drives an external combinational ALU to compute
// result = base + addend*limit with a CHECK/ADD/INC loop.
module alu_loop_seq
    import alu_pkg::*;
#(
    parameter int DATAW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DATAW-1:0] base,
    input  logic [DATAW-1:0] addend,
    input  logic [DATAW-1:0] limit,
    output logic             ready,
    output logic             done,
    output logic [DATAW-1:0] result,
    output logic             last_nz,
    output logic [DATAW-1:0] alu_a,
    output logic [DATAW-1:0] alu_b,
    output logic             alu_op,
    input  logic [DATAW-1:0] alu_out,
    input  logic             alu_p_flag
);

    seq_state_t       state_reg, state_next;
    logic [DATAW-1:0] acc_reg;
    logic [DATAW-1:0] idx_reg;
    logic [DATAW-1:0] addend_reg;
    logic [DATAW-1:0] limit_reg;
    logic [DATAW-1:0] result_reg;
    logic             nz_reg;
    logic             last_nz_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            idx_reg     <= '0;
            addend_reg  <= '0;
            limit_reg   <= '0;
            result_reg  <= '0;
            nz_reg      <= 1'b0;
            last_nz_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        acc_reg     <= base;
                        idx_reg     <= '0;
                        addend_reg  <= addend;
                        limit_reg   <= limit;
                        nz_reg      <= 1'b0;
                        last_nz_reg <= 1'b0;
                    end
                end
                CHECK: begin
                    // Publish on the edge entering DONE so result is valid alongside done.
                    if (!alu_p_flag) begin
                        result_reg  <= acc_reg;
                        last_nz_reg <= nz_reg;
                    end
                end
                ADD: begin
                    acc_reg <= alu_out;
                    nz_reg  <= alu_p_flag;
                end
                INC: begin
                    idx_reg <= alu_out;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        done       = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = ALU_OP_ADD;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = CHECK;
            end
            CHECK: begin
                alu_op     = ALU_OP_INC;
                alu_a      = limit_reg;
                alu_b      = idx_reg;
                state_next = alu_p_flag ? ADD : DONE;
            end
            ADD: begin
                alu_op     = ALU_OP_ADD;
                alu_a      = acc_reg;
                alu_b      = addend_reg;
                state_next = INC;
            end
            INC: begin
                alu_op     = ALU_OP_INC;
                alu_a      = idx_reg;
                alu_b      = limit_reg;
                state_next = CHECK;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign result  = result_reg;
    assign last_nz = last_nz_reg;

endmodule

// File: tb/tb_alu_loop_seq.sv
// Scoreboard bench for alu_loop_seq with a behavioural ALU and a reference
// model of the accumulate loop computed directly from base, addend and limit.
module tb_alu_loop_seq;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] base = '0;
    logic [DW-1:0] addend = '0;
    logic [DW-1:0] limit = '0;
    logic          ready;
    logic          done;
    logic [DW-1:0] result;
    logic          last_nz;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic          alu_op;
    logic [DW-1:0] alu_out;
    logic          alu_p_flag;

    alu_loop_seq #(.DATAW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .base(base), .addend(addend), .limit(limit),
        .ready(ready), .done(done), .result(result), .last_nz(last_nz),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_p_flag(alu_p_flag)
    );

    // Behavioural model of the datapath ALU.
    logic [DW-1:0] add_sum;
    assign add_sum    = alu_a + alu_b;
    assign alu_out    = alu_op ? alu_a + 1'b1 : add_sum;
    assign alu_p_flag = alu_op ? (alu_a > alu_b) : (add_sum != '0);

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] b;
        logic [DW-1:0] a;
        logic [DW-1:0] l;
        int            sc;
    } txn_t;

    txn_t          q[$];
    txn_t          cur;
    bit            act = 0;
    logic [DW-1:0] held_res = '0;
    logic          held_nz = 1'b0;
    int            total = 0;
    int            bad = 0;
    int            ntx = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", nm, cyc, got, exp);
        end
    endtask

    // Monitor: follows each accepted command cycle by cycle and checks done/result.
    always @(negedge clk) begin
        if (!rst_n) begin
            act = 0;
            q.delete();
            held_res = '0;
            held_nz  = 1'b0;
        end else begin
            if (!act && q.size() > 0 && cyc == q[0].sc) begin
                cur = q.pop_front();
                act = 1;
            end
            chk("done_ready_excl", {31'd0, done & ready}, 32'd0);
            if (act) begin
                int            k, n, it, ph;
                logic [DW-1:0] exp_res, exp_acc;
                logic          exp_nz;
                k  = cyc - cur.sc + 1;
                n  = 3 * int'(cur.l) + 2;
                chk("ready_busy", {31'd0, ready}, 32'd0);
                if (k < n) begin
                    it = (k - 1) / 3;
                    ph = (k - 1) % 3;
                    exp_acc = cur.b + cur.a * DW'(it);
                    chk("done_early", {31'd0, done}, 32'd0);
                    if (ph == 0) begin
                        chk("chk_op", {31'd0, alu_op}, 32'd1);
                        chk("chk_a", {16'd0, alu_a}, {16'd0, cur.l});
                        chk("chk_b", {16'd0, alu_b}, it);
                    end else if (ph == 1) begin
                        chk("add_op", {31'd0, alu_op}, 32'd0);
                        chk("add_a", {16'd0, alu_a}, {16'd0, exp_acc});
                        chk("add_b", {16'd0, alu_b}, {16'd0, cur.a});
                    end else begin
                        chk("inc_op", {31'd0, alu_op}, 32'd1);
                        chk("inc_a", {16'd0, alu_a}, it);
                        chk("inc_b", {16'd0, alu_b}, {16'd0, cur.l});
                    end
                end else begin
                    exp_res = cur.b + cur.a * cur.l;
                    exp_nz  = (cur.l != '0) && (exp_res != '0);
                    chk("done_pulse", {31'd0, done}, 32'd1);
                    chk("result", {16'd0, result}, {16'd0, exp_res});
                    chk("last_nz", {31'd0, last_nz}, {31'd0, exp_nz});
                    $display("txn %0d base=0x%04h addend=0x%04h limit=%0d result=0x%04h last_nz=%0d done_cycle=%0d",
                             ntx, cur.b, cur.a, cur.l, result, last_nz, k);
                    ntx++;
                    held_res = exp_res;
                    held_nz  = exp_nz;
                    act = 0;
                end
            end else begin
                chk("idle_done", {31'd0, done}, 32'd0);
                chk("idle_ready", {31'd0, ready}, 32'd1);
                chk("held_result", {16'd0, result}, {16'd0, held_res});
                chk("held_last_nz", {31'd0, last_nz}, {31'd0, held_nz});
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_last_nz", {31'd0, last_nz}, 32'd0);
        chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
        chk("rst_alu_b", {16'd0, alu_b}, 32'd0);
        chk("rst_alu_op", {31'd0, alu_op}, 32'd0);
    endtask

    // Call from just after a falling edge; returns just after a rising edge.
    task automatic issue(input logic [DW-1:0] b, input logic [DW-1:0] a, input logic [DW-1:0] l);
        txn_t t;
        base   = b;
        addend = a;
        limit  = l;
        start  = 1'b1;
        t.b  = b;
        t.a  = a;
        t.l  = l;
        t.sc = cyc + 1;
        q.push_back(t);
        @(posedge clk);
        #1;
        start  = 1'b0;
        base   = DW'($urandom);
        addend = DW'($urandom);
        limit  = DW'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while ((act || q.size() != 0) && t < 3000);
        if (t >= 3000) chk("timeout_wait_done", 32'd1, 32'd0);
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_ignored_start();
        base   = DW'($urandom);
        addend = DW'($urandom);
        limit  = DW'($urandom_range(0, 5));
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        #3;
        check_reset_vals();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        issue(16'd5, 16'd3, 16'd4);          wait_idle();
        issue(16'd9, 16'd7, 16'd0);          wait_idle();
        issue(16'hFFFF, 16'd2, 16'd1);       wait_idle();
        issue(16'hFFFE, 16'd1, 16'd2);       wait_idle();
        issue(16'h1234, 16'h0101, 16'd3);    wait_idle();

        // Starts in cycle 3 and in the DONE cycle 14 must be ignored.
        issue(16'd100, 16'd10, 16'd4);
        repeat (2) @(posedge clk);
        #1;
        pulse_ignored_start();
        repeat (10) @(posedge clk);
        #1;
        pulse_ignored_start();
        wait_idle();

        // Reset asserted in cycle 6 of a limit=4 run aborts without done.
        issue(16'd20, 16'd5, 16'd4);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        issue(16'd1, 16'd1, 16'd2);          wait_idle();

        for (int i = 0; i < 25; i++) begin
            logic [DW-1:0] b, a;
            b = DW'($urandom);
            a = DW'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                b = '0;
                a = '0;
            end
            issue(b, a, DW'($urandom_range(0, 12)));
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "global timeout");
    end

endmodule
